// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes (RISC-V funct3),
// FSM state codes and the latency counter width.
package dm_pkg;

  localparam logic [2:0] DM_SZ_B  = 3'b000;
  localparam logic [2:0] DM_SZ_H  = 3'b001;
  localparam logic [2:0] DM_SZ_W  = 3'b010;
  localparam logic [2:0] DM_SZ_BU = 3'b100;
  localparam logic [2:0] DM_SZ_HU = 3'b101;

  localparam logic [1:0] DM_IDLE = 2'd0;
  localparam logic [1:0] DM_BUSY = 2'd1;
  localparam logic [1:0] DM_DONE = 2'd2;

  localparam int unsigned DM_CNT_W = 4;

  function automatic logic dm_size_legal(input logic [2:0] sz);
    return (sz == DM_SZ_B) || (sz == DM_SZ_H) || (sz == DM_SZ_W) ||
           (sz == DM_SZ_BU) || (sz == DM_SZ_HU);
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: load extraction/extension and store lane merging.
// Optional DM_MISALIGN_ERR_EN flags misaligned/illegal accesses instead of masking offsets.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wd,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word,
  output logic [3:0]  o_be,
  output logic        o_err
);

  logic       w_illegal;
  logic       w_is_h;
  logic [1:0] w_off;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_st_data;

  assign w_illegal = !dm_size_legal(i_size);
  assign w_is_h    = (i_size == DM_SZ_H) || (i_size == DM_SZ_HU);

`ifdef DM_MISALIGN_ERR_EN
  logic w_misalign;
  assign w_off      = i_addr_lo;
  assign w_misalign = (w_is_h && i_addr_lo[0]) ||
                      ((i_size == DM_SZ_W) && (i_addr_lo != 2'b00));
  assign o_err      = w_illegal || w_misalign;
`else
  // Without error reporting, offset bits finer than the access size are dropped.
  assign w_off = (i_size == DM_SZ_W) ? 2'b00 :
                 w_is_h              ? {i_addr_lo[1], 1'b0} : i_addr_lo;
  assign o_err = 1'b0;
`endif

  assign w_byte = i_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_ld_data = '0;
    case (i_size)
      DM_SZ_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      DM_SZ_BU: o_ld_data = {24'd0, w_byte};
      DM_SZ_H:  o_ld_data = {{16{w_half[15]}}, w_half};
      DM_SZ_HU: o_ld_data = {16'd0, w_half};
      DM_SZ_W:  o_ld_data = i_word;
      default:  o_ld_data = '0;
    endcase
    if (o_err) o_ld_data = '0;
  end

  always_comb begin
    o_be      = '0;
    w_st_data = '0;
    case (i_size)
      DM_SZ_B: begin
        o_be      = 4'b0001 << w_off;
        w_st_data = {4{i_wd[7:0]}};
      end
      DM_SZ_H: begin
        o_be      = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{i_wd[15:0]}};
      end
      DM_SZ_W: begin
        o_be      = 4'b1111;
        w_st_data = i_wd;
      end
      default: begin
        o_be      = '0;
        w_st_data = '0;
      end
    endcase
    if (o_err) o_be = '0;
  end

  always_comb begin
    o_st_word = i_word;
    for (int unsigned k = 0; k < 4; k++) begin
      if (o_be[k]) o_st_word[8*k +: 8] = w_st_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable latency, word RAM.
// Misalignment error reporting is enabled by defining DM_MISALIGN_ERR_EN.
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_stall_o,
  output logic        mem_err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]             r_mem [0:DEPTH-1];
  logic [1:0]              r_state;
  logic [DM_CNT_W-1:0]     r_cnt;
  logic                    r_we;
  logic [2:0]              r_size;
  logic [DEPTH_LOG2+1:0]   r_addr;
  logic [31:0]             r_wd;
  logic [31:0]             r_rd;
  logic                    r_err;

  logic [31:0]             w_word;
  logic [31:0]             w_ld_data;
  logic [31:0]             w_st_word;
  logic [3:0]              w_be;
  logic                    w_err;
  logic                    w_commit;
  logic                    w_wr_en;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_unused_addr;

  // Address bits above the RAM index are ignored so accesses wrap.
  assign w_unused_addr = ^mem_addr_i[31:DEPTH_LOG2+2];

  assign w_idx    = r_addr[DEPTH_LOG2+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_commit = (r_state == DM_BUSY) && (r_cnt == '0);
  assign w_wr_en  = w_commit && r_we && (w_be != '0) && !reset;

  dm_lane_unit u_lane (
    .i_word    (w_word),
    .i_wd      (r_wd),
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .o_ld_data (w_ld_data),
    .o_st_word (w_st_word),
    .o_be      (w_be),
    .o_err     (w_err)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state <= DM_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        DM_IDLE: begin
          if (mem_req_i) begin
            r_we    <= mem_we_i;
            r_size  <= mem_size_i;
            r_addr  <= mem_addr_i[DEPTH_LOG2+1:0];
            r_wd    <= mem_wd_i;
            r_cnt   <= DM_CNT_W'(LATENCY - 1);
            r_state <= DM_BUSY;
          end
        end
        DM_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Stores leave the read register alone unless the access faulted.
            if (!r_we || w_err) r_rd <= w_ld_data;
            r_err   <= w_err;
            r_state <= DM_DONE;
          end
        end
        default: r_state <= DM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_idx] <= w_st_word;
  end

  assign mem_rd_o    = r_rd;
  assign mem_err_o   = r_err;
  assign mem_stall_o = mem_req_i && (r_state != DM_DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH_LOG2=8).
module tb_data_mem_responder;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [2:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wd_i;
  logic [31:0] mem_rd_o;
  logic        mem_stall_o;
  logic        mem_err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        err;
  int          stalls;

  data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(2), .INIT_FILE("")) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_size_i  (mem_size_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wd_i    (mem_wd_i),
    .mem_rd_o    (mem_rd_o),
    .mem_stall_o (mem_stall_o),
    .mem_err_o   (mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns values seen in DONE.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] o_rd,
                        output logic o_err, output int o_stalls);
    bit done = 0;
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_size_i = sz;
    mem_addr_i = addr;
    mem_wd_i   = wd;
    o_stalls   = 0;
    o_rd       = '0;
    o_err      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (mem_stall_o) o_stalls++;
      else begin
        done  = 1;
        o_rd  = mem_rd_o;
        o_err = mem_err_o;
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
    mem_wd_i  = 32'h5A5A_5A5A;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] exp);
    access(1'b0, sz, addr, 32'h0, rd, err, stalls);
    chk(tag, rd, exp);
  endtask

  task automatic store(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    access(1'b1, sz, addr, wd, rd, err, stalls);
  endtask

  initial begin
    reset = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_size_i = 3'b010; mem_addr_i = '0; mem_wd_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset = 1'b0;
    @(negedge clk_i);
    chk("reset_rd", mem_rd_o, 32'h0);
    chk("reset_err", {31'd0, mem_err_o}, 32'd0);
    chk("reset_stall", {31'd0, mem_stall_o}, 32'd0);
    @(posedge clk_i); #1;

    access(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, err, stalls);
    chk("sw_stall_cycles", stalls, 32'd3);
    chk("sw_err", {31'd0, err}, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'h0, rd, err, stalls);
    chk("lw_stall_cycles", stalls, 32'd3);
    chk("lw_data", rd, 32'h1122_3344);
    @(negedge clk_i);
    chk("rd_held_idle", mem_rd_o, 32'h1122_3344);
    chk("stall_idle", {31'd0, mem_stall_o}, 32'd0);
    @(posedge clk_i); #1;

    store(3'b000, 32'h11, 32'hFFFF_FFAA);
    load_chk("lw_after_sb", 3'b010, 32'h10, 32'h1122_AA44);
    load_chk("lb_0x11", 3'b000, 32'h11, 32'hFFFF_FFAA);
    load_chk("lbu_0x11", 3'b100, 32'h11, 32'h0000_00AA);

    store(3'b001, 32'h12, 32'h1234_8001);
    load_chk("lh_0x12", 3'b001, 32'h12, 32'hFFFF_8001);
    load_chk("lhu_0x12", 3'b101, 32'h12, 32'h0000_8001);
    load_chk("lw_after_sh", 3'b010, 32'h10, 32'h8001_AA44);
    load_chk("lb_0x13", 3'b000, 32'h13, 32'hFFFF_FF80);
    load_chk("lh_0x10", 3'b001, 32'h10, 32'hFFFF_AA44);
    load_chk("lhu_0x10", 3'b101, 32'h10, 32'h0000_AA44);

    store(3'b010, 32'h400, 32'hCAFE_F00D);
    load_chk("lw_alias_0x000", 3'b010, 32'h000, 32'hCAFE_F00D);
    load_chk("lw_0x10_untouched", 3'b010, 32'h10, 32'h8001_AA44);

    load_chk("illegal_size_load", 3'b011, 32'h10, 32'h0);
    store(3'b100, 32'h10, 32'hFFFF_FFFF);
    store(3'b111, 32'h10, 32'hFFFF_FFFF);
    load_chk("no_write_bu_store", 3'b010, 32'h10, 32'h8001_AA44);

    // Reset during the second BUSY cycle aborts the store.
    store(3'b010, 32'h20, 32'h5566_7788);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 3'b010;
    mem_addr_i = 32'h20; mem_wd_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset = 1'b1;
    @(posedge clk_i); #1;
    reset = 1'b0; mem_req_i = 1'b0;
    @(negedge clk_i);
    chk("abort_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("abort_rd_reset", mem_rd_o, 32'h0);
    @(posedge clk_i); #1;
    load_chk("lw_after_abort", 3'b010, 32'h20, 32'h5566_7788);

`ifdef DM_MISALIGN_ERR_EN
    access(1'b0, 3'b010, 32'h22, 32'h0, rd, err, stalls);
    chk("misalign_lw_err", {31'd0, err}, 32'd1);
    chk("misalign_lw_rd", rd, 32'h0);
    @(negedge clk_i);
    chk("misalign_err_pulse", {31'd0, mem_err_o}, 32'd0);
    @(posedge clk_i); #1;
    store(3'b001, 32'h21, 32'h0000_1234);
    chk("misalign_sh_err", {31'd0, err}, 32'd1);
    load_chk("misalign_sh_nowrite", 3'b010, 32'h20, 32'h5566_7788);
    access(1'b0, 3'b110, 32'h20, 32'h0, rd, err, stalls);
    chk("illegal_size_err", {31'd0, err}, 32'd1);
`else
    access(1'b0, 3'b010, 32'h22, 32'h0, rd, err, stalls);
    chk("lw_0x22_masked", rd, 32'h5566_7788);
    chk("lw_0x22_no_err", {31'd0, err}, 32'd0);
    store(3'b001, 32'h21, 32'h0000_1234);
    load_chk("sh_0x21_masked", 3'b010, 32'h20, 32'h5566_1234);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
